// File: rtl/periodic_timer.sv
// periodic_timer: prescaled compare timer with periodic and one-shot modes.
// A prescaler divides the clock into ticks; a main count advances on ticks
// and raises a compare-match event, which sets a sticky interrupt.
module periodic_timer #(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   clear_i,
    input  logic                   oneshot_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    input  logic [WIDTH-1:0]       cmp_i,
    input  logic                   irq_ack_i,
    output logic                   tick_o,
    output logic                   event_o,
    output logic [WIDTH-1:0]       count_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [PRESC_WIDTH-1:0] presc_reg, presc_next;
    logic [WIDTH-1:0]       count_reg, count_next;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   irq_reg, irq_next;

    logic running;
    logic tick;
    logic match;
    logic evt;
    logic do_start;

    // Stop outranks start, so a simultaneous start is simply ignored.
    assign do_start = start_i && !stop_i;

    // Live configuration: presc_i and cmp_i are compared every cycle, never latched.
    assign running = (state_reg == ST_RUN);
    assign tick    = running && (presc_reg == presc_i);
    assign match   = (count_reg == cmp_i);
    assign evt     = tick && match;

    // Next-state logic; clear never affects the state, only the counters.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (do_start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (stop_i)                          state_next = ST_IDLE;
                else if (start_i)                    state_next = ST_RUN;
                else if (evt && oneshot_i)           state_next = ST_DONE;
            end
            ST_DONE: begin
                if (stop_i)        state_next = ST_IDLE;
                else if (do_start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter update: clear/start zero both counters and suppress any pending tick update.
    always_comb begin
        presc_next = presc_reg;
        count_next = count_reg;
        if (clear_i || do_start) begin
            presc_next = '0;
            count_next = '0;
        end else if (tick) begin
            presc_next = '0;
            if (!match) begin
                // Equality-only match: a lowered cmp_i makes the count wrap first.
                count_next = count_reg + WIDTH'(1);
            end else if (!oneshot_i) begin
                count_next = '0;
            end
        end else if (running) begin
            presc_next = presc_reg + PRESC_WIDTH'(1);
        end
    end

    // Sticky interrupt: an event in the same cycle as an ack keeps it set.
    always_comb begin
        irq_next = irq_reg;
        if (evt)            irq_next = 1'b1;
        else if (irq_ack_i) irq_next = 1'b0;
    end

    // State register with registered status flags decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_RUN);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    // Prescaler, main count and interrupt registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_reg <= '0;
            count_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            count_reg <= count_next;
            irq_reg   <= irq_next;
        end
    end

    assign tick_o  = tick;
    assign event_o = evt;
    assign count_o = count_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;
    assign irq_o   = irq_reg;

endmodule

// File: tb/tb_periodic_timer.sv
// Self-checking bench for periodic_timer: directed scenarios with closed-form
// expectations plus randomized command traffic against a behavioural model.
module tb_periodic_timer;

    localparam int TW    = 4;
    localparam int TPW   = 4;
    localparam int CMOD  = 1 << TW;
    localparam int PMOD  = 1 << TPW;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic           clk;
    logic           rst_ni;
    logic           start_i;
    logic           stop_i;
    logic           clear_i;
    logic           oneshot_i;
    logic [TPW-1:0] presc_i;
    logic [TW-1:0]  cmp_i;
    logic           irq_ack_i;
    logic           tick_o;
    logic           event_o;
    logic [TW-1:0]  count_o;
    logic           busy_o;
    logic           done_o;
    logic           irq_o;

    int n_checks;
    int n_fail;

    // behavioural model
    int m_mode, m_p, m_c;
    bit m_irq, m_tick, m_evt;
    int n_mode, n_p, n_c;
    bit n_irq;

    // observed values of the most recent cycle
    logic          obs_tick, obs_evt, obs_busy, obs_done, obs_irq;
    logic [TW-1:0] obs_cnt;

    periodic_timer #(.WIDTH(TW), .PRESC_WIDTH(TPW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .clear_i   (clear_i),
        .oneshot_i (oneshot_i),
        .presc_i   (presc_i),
        .cmp_i     (cmp_i),
        .irq_ack_i (irq_ack_i),
        .tick_o    (tick_o),
        .event_o   (event_o),
        .count_o   (count_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_p    = 0;
        m_c    = 0;
        m_irq  = 1'b0;
    endtask

    // Outputs that depend on the current state and live inputs.
    task automatic model_comb();
        m_tick = (m_mode == M_RUN) && (m_p == int'(presc_i));
        m_evt  = m_tick && (m_c == int'(cmp_i));
    endtask

    // Apply the operating rules to obtain the state after this cycle.
    task automatic model_next();
        n_mode = m_mode;
        n_p    = m_p;
        n_c    = m_c;
        n_irq  = m_evt ? 1'b1 : (irq_ack_i ? 1'b0 : m_irq);
        if (m_tick) begin
            n_p = 0;
            if (!m_evt)         n_c = (m_c + 1) % CMOD;
            else if (!oneshot_i) n_c = 0;
        end else if (m_mode == M_RUN) begin
            n_p = (m_p + 1) % PMOD;
        end
        if (stop_i) begin
            n_mode = M_IDLE;
        end else if (start_i) begin
            n_mode = M_RUN;
            n_p    = 0;
            n_c    = 0;
        end else if (m_evt && oneshot_i) begin
            n_mode = M_DONE;
        end
        if (clear_i) begin
            n_p = 0;
            n_c = 0;
        end
    endtask

    // One clock cycle: compare DUT with the model mid-cycle, then advance.
    task automatic step(input string tag);
        @(negedge clk);
        model_comb();
        chk({tag, ".tick"},  tick_o,  m_tick);
        chk({tag, ".event"}, event_o, m_evt);
        chk({tag, ".count"}, count_o, m_c);
        chk({tag, ".busy"},  busy_o,  m_mode == M_RUN);
        chk({tag, ".done"},  done_o,  m_mode == M_DONE);
        chk({tag, ".irq"},   irq_o,   m_irq);
        obs_tick = tick_o;
        obs_evt  = event_o;
        obs_cnt  = count_o;
        obs_busy = busy_o;
        obs_done = done_o;
        obs_irq  = irq_o;
        model_next();
        @(posedge clk);
        if (!rst_ni) begin
            model_reset();
        end else begin
            m_mode = n_mode;
            m_p    = n_p;
            m_c    = n_c;
            m_irq  = n_irq;
        end
        #1;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        clear_i   = 1'b0;
        irq_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; irq_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        int ev_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_ni = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; irq_ack_i = 1'b0;
        oneshot_i = 1'b0; presc_i = '0; cmp_i = '0;
        model_reset();

        // reset values
        #2;
        chk("rst.tick",  tick_o,  1'b0);
        chk("rst.event", event_o, 1'b0);
        chk("rst.count", count_o, 0);
        chk("rst.busy",  busy_o,  1'b0);
        chk("rst.done",  done_o,  1'b0);
        chk("rst.irq",   irq_o,   1'b0);
        $display("txn reset: outputs checked");
        do_reset();

        // periodic, presc=3 cmp=4
        presc_i = 4'd3; cmp_i = 4'd4; oneshot_i = 1'b0;
        for (int i = 0; i <= 45; i++) begin
            start_i = (i == 0);
            step("s1");
            chk("s1.tick_at",  obs_tick, (i > 0) && (i % 4 == 0));
            chk("s1.evt_at",   obs_evt,  (i > 0) && (i % 20 == 0));
            chk("s1.irq_at",   obs_irq,  i >= 21);
            chk("s1.busy_at",  obs_busy, i >= 1);
            if (i == 21 || i == 41) chk("s1.cnt_zero", obs_cnt, 0);
        end
        $display("txn periodic presc=3 cmp=4: events at 20,40");
        do_reset();

        // presc=0 cmp=0: tick and event every cycle
        presc_i = '0; cmp_i = '0; oneshot_i = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            start_i = (i == 0);
            step("s2");
            chk("s2.tick_at", obs_tick, i >= 1);
            chk("s2.evt_at",  obs_evt,  i >= 1);
            chk("s2.cnt",     obs_cnt,  0);
        end
        $display("txn presc=0 cmp=0: every-cycle events");
        do_reset();

        // one-shot, presc=1 cmp=2, restart at 12
        presc_i = 4'd1; cmp_i = 4'd2; oneshot_i = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            start_i = (i == 0) || (i == 12);
            step("s3");
            chk("s3.evt_at",  obs_evt,  (i == 6) || (i == 18));
            chk("s3.tick_at", obs_tick, (i == 2) || (i == 4) || (i == 6) ||
                                        (i == 14) || (i == 16) || (i == 18));
            chk("s3.done_at", obs_done, ((i >= 7) && (i <= 12)) || (i >= 19));
            chk("s3.busy_at", obs_busy, ((i >= 1) && (i <= 6)) || ((i >= 13) && (i <= 18)));
            if ((i >= 7 && i <= 12) || i >= 19) chk("s3.cnt_hold", obs_cnt, 2);
        end
        $display("txn oneshot presc=1 cmp=2: events at 6,18");
        do_reset();

        // simultaneous commands, presc=0 cmp=2
        presc_i = '0; cmp_i = 4'd2; oneshot_i = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            start_i   = (i == 0) || (i == 6) || (i == 8) || (i == 11);
            stop_i    = (i == 6);
            clear_i   = (i == 11);
            irq_ack_i = (i == 3) || (i == 4);
            step("s4");
            if (i == 3)  chk("s4.evt_ack", obs_evt, 1'b1);
            if (i == 4)  chk("s4.irq_set_wins", obs_irq, 1'b1);
            if (i == 5)  chk("s4.irq_acked", obs_irq, 1'b0);
            if (i == 6)  chk("s4.evt_on_stop", obs_evt, 1'b1);
            if (i == 7)  chk("s4.stop_beats_start", obs_busy, 1'b0);
            if (i == 7)  chk("s4.no_tick_after_stop", obs_tick, 1'b0);
            if (i == 11) chk("s4.cnt_before_clr", obs_cnt, 2);
            if (i == 12) chk("s4.clr_start_busy", obs_busy, 1'b1);
            if (i == 12) chk("s4.clr_start_cnt", obs_cnt, 0);
        end
        $display("txn simultaneous commands");
        do_reset();

        // wrap-around after lowering cmp below the count
        presc_i = '0; oneshot_i = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            start_i = (i == 0);
            cmp_i   = (i >= 10) ? 4'd5 : 4'd15;
            step("s5");
            chk("s5.evt_at", obs_evt, i == 22);
            if (i >= 1 && i <= 22) chk("s5.cnt_seq", obs_cnt, (i - 1) % CMOD);
            if (i == 23) chk("s5.cnt_after", obs_cnt, 0);
        end
        $display("txn wrap-around cmp 15->5 at count 9");
        do_reset();

        // asynchronous reset mid-run
        presc_i = '0; cmp_i = 4'd7; oneshot_i = 1'b0;
        start_i = 1'b1;
        step("s6");
        repeat ($urandom_range(3, 10)) step("s6");
        chk("s6.busy_pre", busy_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("s6.ar.tick",  tick_o,  1'b0);
        chk("s6.ar.event", event_o, 1'b0);
        chk("s6.ar.count", count_o, 0);
        chk("s6.ar.busy",  busy_o,  1'b0);
        chk("s6.ar.done",  done_o,  1'b0);
        chk("s6.ar.irq",   irq_o,   1'b0);
        model_reset();
        step("s6r");
        step("s6r");
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("s6p");
            chk("s6.no_tick", obs_tick, 1'b0);
            chk("s6.idle",    obs_busy, 1'b0);
        end
        $display("txn async reset mid-run");

        // randomized command traffic
        for (int seg = 0; seg < 30; seg++) begin
            presc_i   = TPW'($urandom_range(0, 3));
            cmp_i     = TW'($urandom_range(0, 5));
            oneshot_i = ($urandom_range(0, 1) == 1);
            ev_cnt = 0;
            for (int c = 0; c < 30; c++) begin
                if (c == 0) begin
                    start_i = 1'b1;
                end else begin
                    start_i   = ($urandom_range(0, 11) == 0);
                    stop_i    = ($urandom_range(0, 19) == 0);
                    clear_i   = ($urandom_range(0, 19) == 0);
                    irq_ack_i = ($urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 29) == 0) cmp_i = TW'($urandom_range(0, 15));
                    if ($urandom_range(0, 29) == 0) presc_i = TPW'($urandom_range(0, 3));
                    if ($urandom_range(0, 39) == 0) oneshot_i = ~oneshot_i;
                end
                step("rnd");
                if (obs_evt) ev_cnt++;
            end
            $display("txn random seg=%0d presc=%0d cmp=%0d oneshot=%0d events=%0d",
                     seg, presc_i, cmp_i, oneshot_i, ev_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
